si53xx_config_loader: RTL and testbench
=======================================

# si53xx_config_loader

Sequencer that brings up a Si53xx clock-generator PLL over the existing SPI register interface (read/write/addr/wdata/rdata/done handshake). On `start` it pulses the PLL hardware reset, streams a register map from a synchronous ROM of `{reg_addr, data}` words, and inserts the mandatory post-preamble settle delay. It then polls the device status register until the loss-of-lock flag clears, and reports `cfg_done` or `cfg_error`. It replaces the ad-hoc SPI tester as the production bring-up path beside `si53xx_spi_interface`.

## Interface
Parameters:
- `NUM_ENTRIES`, 512: number of ROM words to write, 1..2^`ROM_AW`.
- `ROM_AW`, 9: ROM address width.
- `PREAMBLE_LEN`, 3: words after which the settle delay is inserted, 0..`NUM_ENTRIES` (0 means no delay).
- `DELAY_CYCLES`, 30_000_000: settle delay in clocks (300 ms at 100 MHz), ≥1.
- `RST_CYCLES`, 1000: width of `pll_reset` pulse, and also the wait after it, ≥1.
- `STATUS_ADDR`, 8'h0C: status register (page 0).
- `LOL_MASK`, 8'h08: lock is good when `(rdata & LOL_MASK) == 0`.
- `POLL_LIMIT`, 1024: maximum status reads before error, ≥1.
- `POLL_GAP`, 1000: idle cycles between status reads.

Ports:
- `clk` input 1: single clock for the block.
- `reset` input 1: synchronous, active-high.
- `start` input 1: level or pulse. Sampled only in IDLE, DONE and ERROR.
- `busy` output 1: high in every state except IDLE, DONE and ERROR.
- `cfg_done` output 1: high in DONE, held until next `start` or `reset`.
- `cfg_error` output 1: high in ERROR, held until next `start` or `reset`.
- `pll_reset` output 1: active-high hardware reset to PLL.
- `rom_addr` output `ROM_AW`: ROM read address.
- `rom_data` input 16: `{reg_addr[15:8], data[7:0]}`, valid 1 cycle after `rom_addr`.
- `if_reset` output 1: reset to SPI interface.
- `if_write` output 1: one-cycle write request.
- `if_read` output 1: one-cycle read request.
- `if_addr` output 8: register address.
- `if_wdata` output 8: write data.
- `if_rdata` input 8: read result, valid in the cycle `if_done` is high.
- `if_done` input 1: one-cycle completion pulse.

## Operation
- States: IDLE, PLL_RST, RST_WAIT, FETCH, ISSUE, WAIT_WR, DELAY, PAGE0, WAIT_PG, POLL_RD, WAIT_RD, GAP, DONE, ERROR.
- IDLE/DONE/ERROR + `start` → PLL_RST: clear index, clear the counters and `cfg_done`/`cfg_error`.
- PLL_RST: `pll_reset`=1 for `RST_CYCLES`, then → RST_WAIT.
- RST_WAIT: `RST_CYCLES` cycles with `pll_reset`=0, then → FETCH.
- FETCH: drive `rom_addr`=index, → ISSUE.
- ISSUE: latch `rom_data` into `if_addr`/`if_wdata`, pulse `if_write`, → WAIT_WR.
- WAIT_WR on `if_done`:
  - increment index.
  - If index == `PREAMBLE_LEN` and `PREAMBLE_LEN`≠0, → DELAY.
  - Else if index == `NUM_ENTRIES`, → PAGE0.
  - Else → FETCH.
- DELAY: count `DELAY_CYCLES`, then → FETCH, or → PAGE0 if index == `NUM_ENTRIES`.
- PAGE0: write addr 8'h01, data 8'h00 (page select), → WAIT_PG; on `if_done` → POLL_RD.
- POLL_RD: `if_addr`=`STATUS_ADDR`, pulse `if_read`, increment poll count, → WAIT_RD.
- WAIT_RD on `if_done`:
  - If lock is good, → DONE.
  - Else if poll count == `POLL_LIMIT`, → ERROR.
  - Else → GAP.
- GAP: `POLL_GAP` cycles, then → POLL_RD.
- `if_reset`=1 in IDLE and in PLL_RST, 0 elsewhere. A SPI transaction never overlaps an interface reset.
- Index width `ROM_AW`+1, so `NUM_ENTRIES` = 2^`ROM_AW` does not wrap.
- `rom_addr` holds its last value outside FETCH.

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `cfg_done`, `cfg_error`, `pll_reset`, `if_write`, `if_read` = 0.
  - `if_reset`=1.
  - `if_addr`, `if_wdata`, `rom_addr` = 0.
- `reset` has priority in any state, including mid-transaction. The block returns to IDLE in the next cycle, and any in-flight `if_done` is ignored.
- `if_addr`/`if_wdata` are stable from the request cycle through the `if_done` cycle.
- `if_write`/`if_read` are exactly one cycle wide. They are never asserted while waiting for `if_done`.
- An `if_done` arriving in any state other than WAIT_* is ignored.
- Per ROM word: 2 cycles (FETCH, ISSUE) + SPI latency.
- First `if_write` occurs `2·RST_CYCLES`+2 cycles after the `start` sample.
- `start` while busy is ignored.
- `start` in DONE/ERROR restarts the full sequence, including `pll_reset`.
- `pll_reset` rises the cycle after `start` is sampled.

## Test plan
- Setup: `NUM_ENTRIES`=4, `PREAMBLE_LEN`=2, `DELAY_CYCLES`=50, `RST_CYCLES`=4, `POLL_GAP`=3, with a behavioural SPI slave model. Pulse `start` → expect:
  - `pll_reset` high 4 cycles.
  - Writes of ROM words 0,1, then a 50-cycle gap, then words 2,3, then write 01←00.
  - Status reads.
  - `cfg_done`=1 once the slave returns 8'h00.
- Slave returns 8'h08 for 3 reads, then 8'h00 → exactly 4 reads spaced ≥3 cycles apart, `cfg_done`=1, `cfg_error`=0.
- `POLL_LIMIT`=5, slave always returns 8'hFF → exactly 5 reads, then `cfg_error`=1, `busy`=0.
- `PREAMBLE_LEN`=0, `NUM_ENTRIES`=1 with rom[0]=16'h0B24 → single write with addr 0x0B, data 0x24, no DELAY state entered.
- Assert `reset` during WAIT_WR, then pulse `if_done` → block is in IDLE with `if_reset`=1 and no further requests. A new `start` replays from ROM index 0.
- `start` held high during the run, and re-pulsed after DONE → no restart while busy. A full second sequence runs after DONE, and `cfg_done` clears the cycle after `start` is sampled.

Source files
------------

// File: rtl/si53xx_config_loader_if.sv
// Register-access bus between the PLL bring-up sequencer and the Si53xx SPI
// register interface.
//   if_reset  : reset to the SPI interface (held while the sequencer is idle)
//   if_write  : one-cycle write request, qualified by if_addr/if_wdata
//   if_read   : one-cycle read request, qualified by if_addr
//   if_addr   : register address, stable from request through completion
//   if_wdata  : write data, stable from request through completion
//   if_rdata  : read result, valid in the cycle if_done is high
//   if_done   : one-cycle completion pulse from the SPI interface
// The sequencer uses the master modport; the SPI interface uses the slave modport.
interface si53xx_config_loader_if;
    logic       if_reset;
    logic       if_write;
    logic       if_read;
    logic [7:0] if_addr;
    logic [7:0] if_wdata;
    logic [7:0] if_rdata;
    logic       if_done;

    modport master (
        output if_reset, if_write, if_read, if_addr, if_wdata,
        input  if_rdata, if_done
    );

    modport slave (
        input  if_reset, if_write, if_read, if_addr, if_wdata,
        output if_rdata, if_done
    );
endinterface

// File: rtl/si53xx_config_loader.sv
// Si53xx PLL bring-up sequencer.
// On start it pulses the PLL hardware reset, waits, streams {reg_addr, data}
// words from a synchronous ROM into the SPI register interface (with a settle
// delay after the preamble words), selects page 0 and polls the status
// register until the loss-of-lock flag clears or the poll budget runs out.
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   start           : begins a bring-up; sampled only in IDLE/DONE/ERROR
//   busy            : high while a bring-up is in progress
//   cfg_done        : lock achieved, held until the next start or reset
//   cfg_error       : poll budget exhausted, held until the next start or reset
//   pll_reset       : active-high hardware reset to the PLL
//   rom_addr        : ROM read address (holds its last value outside FETCH)
//   rom_data        : {reg_addr, data}, valid one cycle after rom_addr
//   spi             : register-access bus (master side)
module si53xx_config_loader #(
    parameter int         NUM_ENTRIES  = 512,
    parameter int         ROM_AW       = 9,
    parameter int         PREAMBLE_LEN = 3,
    parameter int         DELAY_CYCLES = 30_000_000,
    parameter int         RST_CYCLES   = 1000,
    parameter logic [7:0] STATUS_ADDR  = 8'h0C,
    parameter logic [7:0] LOL_MASK     = 8'h08,
    parameter int         POLL_LIMIT   = 1024,
    parameter int         POLL_GAP     = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_error,
    output logic              pll_reset,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    si53xx_config_loader_if.master spi
);

    // One extra index bit so that NUM_ENTRIES == 2**ROM_AW is representable.
    localparam int IDX_W  = ROM_AW + 1;
    localparam int CNT_W  = 32;
    localparam int POLL_W = $clog2(POLL_LIMIT + 1);

    localparam logic [IDX_W-1:0]  NUM_IDX    = IDX_W'(NUM_ENTRIES);
    localparam logic [IDX_W-1:0]  PRE_IDX    = IDX_W'(PREAMBLE_LEN);
    localparam logic [CNT_W-1:0]  RST_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(POLL_GAP - 1);
    localparam logic [POLL_W-1:0] POLL_MAX   = POLL_W'(POLL_LIMIT);

    typedef enum logic [3:0] {
        IDLE, PLL_RST, RST_WAIT, FETCH, ISSUE, WAIT_WR, DELAY,
        PAGE0, WAIT_PG, POLL_RD, WAIT_RD, GAP, DONE, ERROR
    } state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [POLL_W-1:0] poll_reg, poll_next;
    logic [7:0]        addr_reg, addr_next;
    logic [7:0]        wdata_reg, wdata_next;
    logic [ROM_AW-1:0] rom_addr_reg, rom_addr_next;
    logic              write_req, read_req, lock_good;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            cnt_reg      <= '0;
            poll_reg     <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rom_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            cnt_reg      <= cnt_next;
            poll_reg     <= poll_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            rom_addr_reg <= rom_addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        cnt_next      = cnt_reg;
        poll_next     = poll_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        rom_addr_next = rom_addr_reg;
        write_req     = 1'b0;
        read_req      = 1'b0;
        lock_good     = (spi.if_rdata & LOL_MASK) == 8'h00;

        case (state_reg)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_next = PLL_RST;
                    idx_next   = '0;
                    cnt_next   = '0;
                    poll_next  = '0;
                end
            end
            PLL_RST: begin
                if (cnt_reg == RST_LAST) begin
                    state_next = RST_WAIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RST_WAIT: begin
                if (cnt_reg == RST_LAST) begin
                    state_next = FETCH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            FETCH: begin
                rom_addr_next = idx_reg[ROM_AW-1:0];
                state_next    = ISSUE;
            end
            ISSUE: begin
                // rom_data is presented combinationally in the request cycle
                // and latched so it stays stable until if_done.
                addr_next  = rom_data[15:8];
                wdata_next = rom_data[7:0];
                write_req  = 1'b1;
                state_next = WAIT_WR;
            end
            WAIT_WR: begin
                if (spi.if_done) begin
                    idx_next = idx_reg + IDX_W'(1);
                    if (PREAMBLE_LEN != 0 && idx_next == PRE_IDX) begin
                        state_next = DELAY;
                        cnt_next   = '0;
                    end else if (idx_next == NUM_IDX) begin
                        state_next = PAGE0;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            DELAY: begin
                if (cnt_reg == DELAY_LAST) begin
                    cnt_next   = '0;
                    state_next = (idx_reg == NUM_IDX) ? PAGE0 : FETCH;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            PAGE0: begin
                addr_next  = 8'h01;
                wdata_next = 8'h00;
                write_req  = 1'b1;
                state_next = WAIT_PG;
            end
            WAIT_PG: begin
                if (spi.if_done) state_next = POLL_RD;
            end
            POLL_RD: begin
                addr_next  = STATUS_ADDR;
                read_req   = 1'b1;
                poll_next  = poll_reg + POLL_W'(1);
                state_next = WAIT_RD;
            end
            WAIT_RD: begin
                if (spi.if_done) begin
                    if (lock_good) begin
                        state_next = DONE;
                    end else if (poll_reg == POLL_MAX) begin
                        state_next = ERROR;
                    end else if (POLL_GAP == 0) begin
                        state_next = POLL_RD;
                    end else begin
                        state_next = GAP;
                        cnt_next   = '0;
                    end
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = POLL_RD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy         = !(state_reg inside {IDLE, DONE, ERROR});
    assign cfg_done     = (state_reg == DONE);
    assign cfg_error    = (state_reg == ERROR);
    assign pll_reset    = (state_reg == PLL_RST);
    assign rom_addr     = rom_addr_next;
    assign spi.if_reset = (state_reg == IDLE) || (state_reg == PLL_RST);
    assign spi.if_write = write_req;
    assign spi.if_read  = read_req;
    assign spi.if_addr  = addr_next;
    assign spi.if_wdata = wdata_next;

endmodule

// File: tb/tb_si53xx_config_loader.sv
// Bench for si53xx_config_loader: two instances (a 4-word map with a 2-word
// preamble, and a 1-word map without preamble), each with a ROM and a
// randomized-latency SPI slave model that logs every request it sees.
`timescale 1ns/1ps
module tb_si53xx_config_loader;
    localparam int         N_INST = 2;
    localparam int         ROM_AW = 4;
    localparam int         NUM_E [N_INST] = '{4, 1};
    localparam int         PRE_E [N_INST] = '{2, 0};
    localparam int         DELAY  = 50;
    localparam int         RSTC   = 4;
    localparam int         GAPC   = 3;
    localparam int         PLIM   = 5;
    localparam logic [7:0] STATUS = 8'h0C;

    typedef enum int {EV_PRST, EV_WR, EV_RD, EV_BAD} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    function automatic ev_t mk_ev(ev_kind_t k, logic [7:0] a, logic [7:0] d, int c);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.cyc = c;
        return e;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              srst;
    logic [N_INST-1:0] start, busy, cfg_done, cfg_error, pll_reset;
    logic [N_INST-1:0] hold, manual_done;
    logic [15:0]       rom_img [N_INST][16];
    int                bad_until [N_INST];
    logic [7:0]        bad_val [N_INST];
    int                checks = 0;
    int                failures = 0;
    ev_t               exp_q [$];
    bit                exp_ok;

    for (genvar gi = 0; gi < N_INST; gi++) begin : g_dut
        si53xx_config_loader_if spi ();
        logic [ROM_AW-1:0] rom_addr;
        logic [15:0]       rom_q;
        ev_t               log_q [$];
        logic              pend = 1'b0;
        logic              pis_rd = 1'b0;
        logic              done_r = 1'b0;
        logic [7:0]        rdata_r = 8'h00;
        logic [7:0]        paddr = 8'h00;
        logic [7:0]        pwdata = 8'h00;
        int                lat = 0;
        int                rd_total = 0;

        si53xx_config_loader #(
            .NUM_ENTRIES(NUM_E[gi]), .ROM_AW(ROM_AW), .PREAMBLE_LEN(PRE_E[gi]),
            .DELAY_CYCLES(DELAY), .RST_CYCLES(RSTC), .STATUS_ADDR(STATUS),
            .LOL_MASK(8'h08), .POLL_LIMIT(PLIM), .POLL_GAP(GAPC)
        ) dut (
            .clk(clk), .reset(srst), .start(start[gi]), .busy(busy[gi]),
            .cfg_done(cfg_done[gi]), .cfg_error(cfg_error[gi]),
            .pll_reset(pll_reset[gi]), .rom_addr(rom_addr), .rom_data(rom_q),
            .spi(spi)
        );

        always @(posedge clk) rom_q <= rom_img[gi][rom_addr];

        assign spi.if_done  = done_r | manual_done[gi];
        assign spi.if_rdata = rdata_r;

        // SPI slave model: accepts one request at a time, answers after a
        // random latency, and logs requests plus any protocol violation.
        always @(posedge clk) begin
            done_r <= 1'b0;
            if (pll_reset[gi]) log_q.push_back(mk_ev(EV_PRST, 8'h00, 8'h00, cyc));
            if (srst || spi.if_reset) begin
                pend <= 1'b0;
                if (spi.if_write || spi.if_read)
                    log_q.push_back(mk_ev(EV_BAD, spi.if_addr, spi.if_wdata, cyc));
            end else if (pend) begin
                if (spi.if_write || spi.if_read || spi.if_addr !== paddr || spi.if_wdata !== pwdata)
                    log_q.push_back(mk_ev(EV_BAD, spi.if_addr, spi.if_wdata, cyc));
                if (lat <= 1) begin
                    pend    <= 1'b0;
                    done_r  <= 1'b1;
                    rdata_r <= (pis_rd && rd_total <= bad_until[gi]) ? bad_val[gi] : 8'h00;
                end else begin
                    lat <= lat - 1;
                end
            end else if (spi.if_write || spi.if_read) begin
                if (spi.if_write && spi.if_read)
                    log_q.push_back(mk_ev(EV_BAD, spi.if_addr, spi.if_wdata, cyc));
                log_q.push_back(mk_ev(spi.if_read ? EV_RD : EV_WR, spi.if_addr, spi.if_wdata, cyc));
                if (spi.if_read) rd_total <= rd_total + 1;
                pend   <= !hold[gi];
                lat    <= int'($urandom_range(1, 4));
                paddr  <= spi.if_addr;
                pwdata <= spi.if_wdata;
                pis_rd <= spi.if_read;
            end
        end
    end

    function automatic int log_size(input int inst);
        if (inst == 0) return g_dut[0].log_q.size();
        return g_dut[1].log_q.size();
    endfunction

    function automatic ev_t log_at(input int inst, input int k);
        if (inst == 0) return g_dut[0].log_q[k];
        return g_dut[1].log_q[k];
    endfunction

    // Reference model: the transaction list a bring-up must produce.
    function automatic void build_expected(input int inst, input int nbad);
        int nreads;
        logic [15:0] w;
        exp_q.delete();
        for (int i = 0; i < NUM_E[inst]; i++) begin
            w = rom_img[inst][i];
            exp_q.push_back(mk_ev(EV_WR, w[15:8], w[7:0], 0));
        end
        exp_q.push_back(mk_ev(EV_WR, 8'h01, 8'h00, 0));
        nreads = (nbad < PLIM) ? nbad + 1 : PLIM;
        for (int r = 0; r < nreads; r++) exp_q.push_back(mk_ev(EV_RD, STATUS, 8'h00, 0));
        exp_ok = (nbad < PLIM);
    endfunction

    task automatic run_seq(input int inst, input int nbad, input int hold_cyc, input string name);
        int  base, s, rd_before, prst_n, prst_first, prst_last, bad_n, min_rd_gap;
        int  wr_cyc [$];
        int  rd_cyc [$];
        ev_t got [$];
        ev_t e;
        bit  finished;
        logic [3:0] flags;
        logic [2:0] outcome, want;

        base = log_size(inst);
        rd_before = 0;
        for (int k = 0; k < base; k++) if (log_at(inst, k).kind == EV_RD) rd_before++;
        bad_until[inst] = rd_before + nbad;
        build_expected(inst, nbad);

        @(posedge clk); #1;
        start[inst] = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        flags = {busy[inst], pll_reset[inst], cfg_done[inst], cfg_error[inst]};
        checks++;
        if (flags !== 4'b1100) begin
            failures++;
            $display("FAIL %s start_response {busy,pll_reset,done,error} got=%b want=1100", name, flags);
        end
        repeat (hold_cyc) begin @(posedge clk); #1; end
        start[inst] = 1'b0;

        finished = 1'b0;
        for (int c = 0; c < 4000 && !finished; c++) begin
            if (!busy[inst]) finished = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL %s timeout busy got=%b want=0 after 4000 cycles", name, busy[inst]);
        end

        prst_n = 0; prst_first = -1; prst_last = -1; bad_n = 0;
        for (int k = base; k < log_size(inst); k++) begin
            e = log_at(inst, k);
            case (e.kind)
                EV_PRST: begin
                    if (prst_first < 0) prst_first = e.cyc;
                    prst_last = e.cyc;
                    prst_n++;
                end
                EV_WR:   begin got.push_back(e); wr_cyc.push_back(e.cyc); end
                EV_RD:   begin got.push_back(e); rd_cyc.push_back(e.cyc); end
                default: bad_n++;
            endcase
        end

        checks++;
        if (prst_n !== RSTC || prst_first !== s + 1 || prst_last !== s + RSTC) begin
            failures++;
            $display("FAIL %s pll_reset_pulse got=%0d cycles [%0d..%0d] want=%0d cycles [%0d..%0d]",
                     name, prst_n, prst_first, prst_last, RSTC, s + 1, s + RSTC);
        end
        checks++;
        if (wr_cyc.size() == 0 || wr_cyc[0] !== s + 2 * RSTC + 2) begin
            failures++;
            $display("FAIL %s first_write_cycle got=%0d want=%0d", name,
                     (wr_cyc.size() == 0) ? -1 : wr_cyc[0], s + 2 * RSTC + 2);
        end
        checks++;
        if (got.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL %s txn_count got=%0d want=%0d", name, got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            $display("[%s] txn %0d %s addr=%02h data=%02h cyc=%0d", name, i,
                     got[i].kind.name(), got[i].addr, got[i].data, got[i].cyc);
            checks++;
            if (got[i].kind !== exp_q[i].kind || got[i].addr !== exp_q[i].addr ||
                (exp_q[i].kind == EV_WR && got[i].data !== exp_q[i].data)) begin
                failures++;
                $display("FAIL %s txn_%0d got=%s %02h/%02h want=%s %02h/%02h", name, i,
                         got[i].kind.name(), got[i].addr, got[i].data,
                         exp_q[i].kind.name(), exp_q[i].addr, exp_q[i].data);
            end
        end
        if (PRE_E[inst] > 0 && wr_cyc.size() > PRE_E[inst]) begin
            checks++;
            if (wr_cyc[PRE_E[inst]] - wr_cyc[PRE_E[inst] - 1] < DELAY + 4) begin
                failures++;
                $display("FAIL %s settle_delay got=%0d want>=%0d", name,
                         wr_cyc[PRE_E[inst]] - wr_cyc[PRE_E[inst] - 1], DELAY + 4);
            end
        end else if (PRE_E[inst] == 0 && wr_cyc.size() >= 2) begin
            checks++;
            if (wr_cyc[1] - wr_cyc[0] >= DELAY) begin
                failures++;
                $display("FAIL %s no_delay got=%0d want<%0d", name, wr_cyc[1] - wr_cyc[0], DELAY);
            end
        end
        if (rd_cyc.size() >= 2) begin
            min_rd_gap = 1 << 30;
            for (int i = 1; i < rd_cyc.size(); i++)
                if (rd_cyc[i] - rd_cyc[i-1] < min_rd_gap) min_rd_gap = rd_cyc[i] - rd_cyc[i-1];
            checks++;
            if (min_rd_gap < GAPC + 3) begin
                failures++;
                $display("FAIL %s read_spacing got=%0d want>=%0d", name, min_rd_gap, GAPC + 3);
            end
        end
        checks++;
        if (bad_n !== 0) begin
            failures++;
            $display("FAIL %s protocol_violations got=%0d want=0", name, bad_n);
        end
        outcome = {cfg_done[inst], cfg_error[inst], busy[inst]};
        want    = exp_ok ? 3'b100 : 3'b010;
        checks++;
        if (outcome !== want) begin
            failures++;
            $display("FAIL %s outcome {done,error,busy} got=%b want=%b", name, outcome, want);
        end
    endtask

    task automatic randomize_rom(input int inst);
        for (int i = 0; i < 16; i++) rom_img[inst][i] = 16'($urandom);
    endtask

    task automatic test_reset();
        logic [7:0]  ctl;
        logic [15:0] bus;
        srst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ctl = {busy[0], cfg_done[0], cfg_error[0], pll_reset[0], g_dut[0].spi.if_write,
               g_dut[0].spi.if_read, g_dut[0].spi.if_reset, 1'b0};
        checks++;
        if (ctl !== 8'b0000_0010) begin
            failures++;
            $display("FAIL reset_ctl {busy,done,err,pll,wr,rd,ifrst,0} got=%b want=00000010", ctl);
        end
        bus = {g_dut[0].spi.if_addr, g_dut[0].spi.if_wdata};
        checks++;
        if (bus !== 16'h0000) begin
            failures++;
            $display("FAIL reset_bus {addr,wdata} got=%h want=0000", bus);
        end
        checks++;
        if (g_dut[0].rom_addr !== '0) begin
            failures++;
            $display("FAIL reset_rom_addr got=%h want=0", g_dut[0].rom_addr);
        end
        srst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lock_after_polls();
        randomize_rom(0);
        bad_val[0] = 8'h08 | 8'($urandom);
        run_seq(0, 3, 0, "lock_after_3");
    endtask

    task automatic test_poll_limit();
        bad_val[0] = 8'hFF;
        run_seq(0, 1000, 0, "poll_limit");
    endtask

    task automatic test_single_entry();
        rom_img[1][0] = 16'h0B24;
        bad_val[1] = 8'h08;
        run_seq(1, int'($urandom_range(0, 2)), 0, "single_entry");
    endtask

    task automatic test_reset_mid_write();
        int  base, n, extra;
        bit  got_wr;
        logic [1:0] st;
        randomize_rom(0);
        hold[0] = 1'b1;
        base = log_size(0);
        @(posedge clk); #1; start[0] = 1'b1;
        @(posedge clk); #1; start[0] = 1'b0;
        got_wr = 1'b0;
        for (int c = 0; c < 200 && !got_wr; c++) begin
            for (int k = base; k < log_size(0); k++) if (log_at(0, k).kind == EV_WR) got_wr = 1'b1;
            if (!got_wr) begin @(posedge clk); #1; end
        end
        checks++;
        if (!got_wr) begin
            failures++;
            $display("FAIL mid_reset first_write got=none want=write within 200 cycles");
        end
        @(posedge clk); #1;
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        manual_done[0] = 1'b1;
        @(posedge clk); #1;
        manual_done[0] = 1'b0;
        n = log_size(0);
        repeat (20) @(posedge clk);
        #1;
        st = {busy[0], g_dut[0].spi.if_reset};
        checks++;
        if (st !== 2'b01) begin
            failures++;
            $display("FAIL mid_reset idle {busy,if_reset} got=%b want=01", st);
        end
        extra = 0;
        for (int k = n; k < log_size(0); k++) if (log_at(0, k).kind != EV_PRST) extra++;
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL mid_reset stray_requests got=%0d want=0", extra);
        end
        hold[0] = 1'b0;
        run_seq(0, int'($urandom_range(0, 2)), 0, "replay_after_reset");
    endtask

    task automatic test_back_to_back();
        bad_val[0] = 8'h08 | 8'($urandom);
        run_seq(0, int'($urandom_range(0, 3)), 40, "start_held");
        repeat (5) @(posedge clk);
        #1;
        randomize_rom(0);
        run_seq(0, int'($urandom_range(0, 3)), 0, "restart_after_done");
    endtask

    initial begin
        srst = 1'b1;
        start = '0;
        hold = '0;
        manual_done = '0;
        for (int i = 0; i < N_INST; i++) begin
            bad_until[i] = 0;
            bad_val[i] = 8'h08;
            randomize_rom(i);
        end
        test_reset();
        test_lock_after_polls();
        test_poll_limit();
        test_single_entry();
        test_reset_mid_write();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
